led_blinker_multi: RTL and testbench

- Parametrised multi-channel LED driver: one shared prescaler generates a periodic tick, and each channel independently runs one of four modes (off, on, blink, pattern).
- Successor to the fixed divide-chain blinker: the division ratio, channel count, pattern length and output polarity are parameters, and it adds runtime mode control, global enable and phase sync.
- Sits between the board clock/reset inputs and the LED output pins.

---
 rtl/led_blinker_multi.sv | 106 ++++++++++
 tb/tb_led_blinker_multi.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/led_blinker_multi.sv
// Multi-channel LED driver: one shared prescaler tick, per-channel off/on/blink/pattern modes.
// Every output comes from a flop, so no input reaches LED or TICK combinationally.
//   mode | meaning
//   0    | off: LED logically 0
//   1    | on: LED logically 1
//   2    | blink: LED follows phase, which toggles every tick
//   3    | pattern: LED shows PATTERN bit idx, and idx advances every tick
module led_blinker_multi #(
  parameter int                  TICK_DIV  = 5000000,
  parameter int                  CHANNELS  = 2,
  parameter int                  PATTERN_W = 8,
  parameter logic [CHANNELS-1:0] INVERT    = '0
) (
  input  logic                            CLK,
  input  logic                            RESET,
  input  logic                            EN,
  input  logic                            SYNC,
  input  logic [2*CHANNELS-1:0]           MODE,
  input  logic [PATTERN_W*CHANNELS-1:0]   PATTERN,
  output logic [CHANNELS-1:0]             LED,
  output logic                            TICK
);

  localparam int CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int IDX_W = $clog2(PATTERN_W);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TICK_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(PATTERN_W - 1);

  localparam logic [1:0] MODE_OFF   = 2'd0;
  localparam logic [1:0] MODE_ON    = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;

  logic [CNT_W-1:0]               cnt_q, cnt_d;
  logic                           tick_q, tick_d;
  logic                           tick_i;
  logic [CHANNELS-1:0]            phase_q, phase_d;
  logic [CHANNELS-1:0][IDX_W-1:0] idx_q, idx_d;
  logic [2*CHANNELS-1:0]          mode_q, mode_d;
  logic [CHANNELS-1:0]            led_q, led_d;

  logic [1:0]                     ch_mode;
  logic [PATTERN_W-1:0]           ch_pat;
  logic                           ch_lvl;

  always_comb begin
    tick_i = EN && (cnt_q == CNT_MAX);
    cnt_d  = cnt_q;
    if (SYNC || tick_i) begin
      cnt_d = '0;
    end else if (EN) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    // A sync restart suppresses the tick that would otherwise land on the same edge.
    tick_d = tick_i && !SYNC;
    mode_d = MODE;
  end

  always_comb begin
    phase_d = phase_q;
    idx_d   = idx_q;
    led_d   = '0;
    ch_mode = MODE_OFF;
    ch_pat  = '0;
    ch_lvl  = 1'b0;
    for (int i = 0; i < CHANNELS; i++) begin
      ch_mode = MODE[2*i +: 2];
      ch_pat  = PATTERN[PATTERN_W*i +: PATTERN_W];
      if (SYNC || (ch_mode != mode_q[2*i +: 2])) begin
        phase_d[i] = 1'b0;
        idx_d[i]   = '0;
      end else if (tick_i) begin
        phase_d[i] = ~phase_q[i];
        idx_d[i]   = (idx_q[i] == IDX_MAX) ? '0 : idx_q[i] + IDX_W'(1);
      end
      case (ch_mode)
        MODE_OFF:   ch_lvl = 1'b0;
        MODE_ON:    ch_lvl = 1'b1;
        MODE_BLINK: ch_lvl = phase_d[i];
        default:    ch_lvl = ch_pat[idx_d[i]];
      endcase
      led_d[i] = ch_lvl ^ INVERT[i];
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      cnt_q   <= '0;
      tick_q  <= 1'b0;
      phase_q <= '0;
      idx_q   <= '0;
      mode_q  <= '0;
      led_q   <= INVERT;
    end else begin
      cnt_q   <= cnt_d;
      tick_q  <= tick_d;
      phase_q <= phase_d;
      idx_q   <= idx_d;
      mode_q  <= mode_d;
      led_q   <= led_d;
    end
  end

  assign LED  = led_q;
  assign TICK = tick_q;

endmodule

// File: tb/tb_led_blinker_multi.sv
// Scoreboard bench for led_blinker_multi: directed sequences then random stimulus,
// expected outputs from a tick-counting reference model.
module tb_led_blinker_multi;

  localparam int          TD  = 4;
  localparam int          CH  = 2;
  localparam int          PW  = 4;
  localparam logic [1:0]  INV = 2'b10;

  logic          CLK = 1'b0;
  logic          RESET = 1'b1;
  logic          EN = 1'b0;
  logic          SYNC = 1'b0;
  logic [3:0]    MODE = '0;
  logic [7:0]    PATTERN = '0;
  logic [1:0]    LED;
  logic          TICK;

  led_blinker_multi #(
    .TICK_DIV(TD), .CHANNELS(CH), .PATTERN_W(PW), .INVERT(INV)
  ) dut (
    .CLK(CLK), .RESET(RESET), .EN(EN), .SYNC(SYNC),
    .MODE(MODE), .PATTERN(PATTERN), .LED(LED), .TICK(TICK)
  );

  always #5 CLK = ~CLK;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         armed = 0;
  logic [2:0] sb_q[$];

  // Reference state: enabled cycles since restart, and ticks seen by each channel since its last clear.
  int         en_cycles = 0;
  int         ch_ticks[CH];
  logic [1:0] prev_mode[CH];

  task automatic step(input logic r, input logic en, input logic sy,
                      input logic [3:0] md, input logic [7:0] pt);
    logic       tk;
    logic       exp_tick;
    logic [1:0] exp_led;
    logic [1:0] m;
    logic [PW-1:0] p;
    logic       l;
    @(negedge CLK);
    RESET = r; EN = en; SYNC = sy; MODE = md; PATTERN = pt;
    if (r) begin
      en_cycles = 0;
      for (int i = 0; i < CH; i++) begin
        ch_ticks[i] = 0;
        prev_mode[i] = 2'd0;
      end
      exp_tick = 1'b0;
      exp_led  = INV;
    end else begin
      tk = en && (((en_cycles + 1) % TD) == 0);
      if (sy) en_cycles = 0;
      else if (en) en_cycles = en_cycles + 1;
      exp_tick = tk && !sy;
      exp_led  = '0;
      for (int i = 0; i < CH; i++) begin
        m = md[2*i +: 2];
        p = pt[PW*i +: PW];
        if (sy || (m != prev_mode[i])) ch_ticks[i] = 0;
        else if (tk) ch_ticks[i] = ch_ticks[i] + 1;
        prev_mode[i] = m;
        case (m)
          2'd0: l = 1'b0;
          2'd1: l = 1'b1;
          2'd2: l = ((ch_ticks[i] % 2) == 1);
          default: l = p[ch_ticks[i] % PW];
        endcase
        exp_led[i] = l ^ INV[i];
      end
    end
    sb_q.push_back({exp_tick, exp_led});
    armed = 1;
  endtask

  task automatic run(input int n, input logic en, input logic [3:0] md, input logic [7:0] pt);
    for (int k = 0; k < n; k++) step(1'b0, en, 1'b0, md, pt);
  endtask

  // Monitor: every edge presents a new LED/TICK pair; compare against the oldest prediction.
  initial begin
    logic [2:0] exp;
    forever begin
      @(posedge CLK);
      #1;
      cyc++;
      if (armed) begin
        if (sb_q.size() == 0) begin
          total++; bad++;
          $display("FAIL sb_empty cycle=%0d no expected entry queued", cyc);
        end else begin
          exp = sb_q.pop_front();
          total++;
          if (TICK !== exp[2]) begin
            bad++;
            $display("FAIL tick cycle=%0d got=%b want=%b", cyc, TICK, exp[2]);
          end
          total++;
          if (LED !== exp[1:0]) begin
            bad++;
            $display("FAIL led cycle=%0d got=%b want=%b", cyc, LED, exp[1:0]);
          end
        end
      end
    end
  end

  initial begin
    logic [3:0] md;
    logic [7:0] pt;
    logic r, en, sy;
    for (int i = 0; i < CH; i++) begin
      ch_ticks[i] = 0;
      prev_mode[i] = 2'd0;
    end
    // Reset held with both channels on, then release.
    for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 4'b0101, 8'h00);
    run(12, 1'b1, 4'b0101, 8'h00);
    // ch0 blink, ch1 pattern 0110.
    run(18, 1'b1, 4'b1110, 8'h60);
    // ch0 switches to pattern 0001 while ch1 keeps running.
    run(3, 1'b1, 4'b1111, 8'h61);
    run(8, 1'b1, 4'b1111, 8'h61);
    // Freeze, resume, then sync pulse.
    run(2, 1'b1, 4'b1110, 8'h60);
    run(10, 1'b0, 4'b1110, 8'h60);
    run(5, 1'b1, 4'b1110, 8'h60);
    step(1'b0, 1'b1, 1'b1, 4'b1110, 8'h60);
    run(9, 1'b1, 4'b1110, 8'h60);
    step(1'b0, 1'b0, 1'b1, 4'b1110, 8'h60);
    run(6, 1'b1, 4'b1110, 8'h60);
    // Reset mid-pattern, then pattern restarts from bit 0.
    step(1'b1, 1'b1, 1'b0, 4'b1111, 8'h6A);
    run(20, 1'b1, 4'b1111, 8'h6A);
    // Random phase.
    md = 4'b1110; pt = 8'h6A;
    for (int k = 0; k < 3000; k++) begin
      r  = ($urandom_range(0, 99) == 0);
      en = ($urandom_range(0, 99) < 85);
      sy = ($urandom_range(0, 39) == 0);
      for (int i = 0; i < CH; i++)
        if ($urandom_range(0, 19) == 0) md[2*i +: 2] = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 14) == 0) pt = 8'($urandom);
      step(r, en, sy, md, pt);
    end
    @(posedge CLK);
    #2;
    if (sb_q.size() != 0) begin
      total++; bad++;
      $display("FAIL sb_drain leftover=%0d want=0", sb_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
